// File: rtl/sign_narrow_pkg.sv
// Shared widths and the saturation-constant helper for the sign narrowing unit.
package sign_pkg;

  localparam int DATA_W = 8;
  localparam int CNT_W  = 8;

  // Largest positive (neg=0) or most negative (neg=1) value of a w-bit field,
  // right-aligned in a DATA_W word.
  function automatic logic [DATA_W-1:0] sat_const(input int w, input logic neg);
    logic [DATA_W-1:0] one;
    one = {{(DATA_W-1){1'b0}}, 1'b1};
    if (neg) sat_const = one << (w - 1);
    else     sat_const = (one << (w - 1)) - one;
  endfunction

endpackage

// File: rtl/sign_narrow_classify.sv
// Combinational fit test and narrowing of one 8-bit two's-complement value.
module narrow_classify
  import sign_pkg::*;
#(
  parameter int OUT_W = 4
) (
  input  logic [DATA_W-1:0] value,
  input  logic              sat_en,
  output logic [OUT_W-1:0]  data,
  output logic              ovf
);

  logic [DATA_W-OUT_W:0] upper;
  logic                  fit;
  logic [DATA_W-1:0]     satv;

  // The value fits when everything from the new sign bit upward is a copy of it.
  assign upper = value[DATA_W-1:OUT_W-1];
  assign fit   = (&upper) | ~(|upper);
  assign satv  = sat_const(OUT_W, value[DATA_W-1]);

  always_comb begin
    data = value[OUT_W-1:0];
    ovf  = ~fit;
    if (!fit && sat_en) data = satv[OUT_W-1:0];
  end

endmodule

// File: rtl/sign_narrow.sv
// Two-stage valid/ready narrowing pipeline with a saturating overflow counter.
module sign_narrow
  import sign_pkg::*;
#(
  parameter int OUT_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              sat_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic [DATA_W-1:0] out_ext,
  output logic              out_ovf,
  output logic [CNT_W-1:0]  ovf_count,
  input  logic              cnt_clr
);

  logic              s1_valid;
  logic [DATA_W-1:0] s1_data;
  logic              s1_sat;
  logic              s2_valid;
  logic [OUT_W-1:0]  s2_data;
  logic              s2_ovf;
  logic              s2_load;
  logic [OUT_W-1:0]  cls_data;
  logic              cls_ovf;
  logic              ovf_fire;

  narrow_classify #(.OUT_W(OUT_W)) u_classify (
    .value  (s1_data),
    .sat_en (s1_sat),
    .data   (cls_data),
    .ovf    (cls_ovf)
  );

  assign s2_load  = !s2_valid || out_ready;
  assign in_ready = !s1_valid || s2_load;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_sat   <= 1'b0;
    end else if (in_valid && in_ready) begin
      s1_valid <= 1'b1;
      s1_data  <= in_data;
      s1_sat   <= sat_en;
    end else if (s2_load) begin
      s1_valid <= 1'b0;
    end
  end

  // S2 payload only changes when a real word moves in, so held outputs stay stable.
  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid <= 1'b0;
      s2_data  <= '0;
      s2_ovf   <= 1'b0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_data <= cls_data;
        s2_ovf  <= cls_ovf;
      end
    end
  end

  assign ovf_fire = s2_valid && out_ready && s2_ovf;

  always_ff @(posedge clk) begin
    if (reset || cnt_clr)                 ovf_count <= '0;
    else if (ovf_fire && !(&ovf_count))   ovf_count <= ovf_count + 1'b1;
  end

  assign out_valid = s2_valid;
  assign out_data  = s2_data;
  assign out_ovf   = s2_ovf;
  assign out_ext   = {{(DATA_W-OUT_W){s2_data[OUT_W-1]}}, s2_data};

endmodule

// File: tb/tb_sign_narrow.sv
// Directed and randomized checks of sign_narrow with OUT_W=4.
module tb_sign_narrow;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       sat_en;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic [7:0] out_ext;
  logic       out_ovf;
  logic [7:0] ovf_count;
  logic       cnt_clr;

  int checks = 0;
  int errors = 0;

  sign_narrow #(.OUT_W(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .sat_en    (sat_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ext   (out_ext),
    .out_ovf   (out_ovf),
    .ovf_count (ovf_count),
    .cnt_clr   (cnt_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference narrowing to a signed 4-bit field, computed on integer values.
  task automatic ref_narrow(input logic [7:0] v, input logic sat, output logic [3:0] d,
                            output logic ovf);
    int sv;
    sv  = int'($signed(v));
    ovf = (sv < -8) || (sv > 7);
    if (ovf && sat) d = (sv < 0) ? 4'h8 : 4'h7;
    else            d = v[3:0];
  endtask

  // One word through an otherwise idle pipe with out_ready high.
  task automatic send_one(input string tag, input logic [7:0] d, input logic s,
                          input logic [3:0] ed, input logic [7:0] ee, input logic eo);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = d;
    sat_en    = s;
    tick();
    in_valid = 1'b0;
    check({tag, "_lat1"}, out_valid, 1'b0);
    tick();
    check({tag, "_valid"}, out_valid, 1'b1);
    check({tag, "_data"}, out_data, ed);
    check({tag, "_ext"}, out_ext, ee);
    check({tag, "_ovf"}, out_ovf, eo);
    tick();
    check({tag, "_drained"}, out_valid, 1'b0);
  endtask

  logic [11:0] q[$];
  logic [3:0]  md;
  logic        mo;
  logic [11:0] ent;
  int          idx;
  int          got;
  int          sent;
  int          recv;
  int          ovfs;
  int          cyc;

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    sat_en    = 1'b0;
    out_ready = 1'b0;
    cnt_clr   = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 4'h0);
    check("rst_out_ext", out_ext, 8'h00);
    check("rst_out_ovf", out_ovf, 1'b0);
    check("rst_ovf_count", ovf_count, 8'h00);
    check("rst_in_ready", in_ready, 1'b1);

    send_one("v05", 8'h05, 1'b0, 4'h5, 8'h05, 1'b0);
    send_one("vFA", 8'hFA, 1'b0, 4'hA, 8'hFA, 1'b0);
    send_one("v09s", 8'h09, 1'b1, 4'h7, 8'h07, 1'b1);
    send_one("v09t", 8'h09, 1'b0, 4'h9, 8'hF9, 1'b1);
    send_one("v80s", 8'h80, 1'b1, 4'h8, 8'hF8, 1'b1);
    send_one("v08s", 8'h08, 1'b1, 4'h7, 8'h07, 1'b1);
    send_one("vF8", 8'hF8, 1'b1, 4'h8, 8'hF8, 1'b0);
    send_one("vF7t", 8'hF7, 1'b0, 4'h7, 8'h07, 1'b1);
    check("cnt_after_directed", ovf_count, 8'd5);

    // Backpressure: stream 1..4 with out_ready low for 4 cycles.
    idx = 0;
    sat_en = 1'b0;
    for (int c = 0; c < 4; c++) begin
      out_ready = 1'b0;
      in_valid  = (idx < 4);
      in_data   = 8'(idx + 1);
      #1;
      if (c >= 2) check("bp_in_ready_low", in_ready, 1'b0);
      if (c == 3) check("bp_hold_data", out_data, 4'h1);
      if (in_valid && in_ready) idx++;
      tick();
    end
    check("bp_accepted", idx, 2);
    got = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 20 && got < 4; c++) begin
      in_valid = (idx < 4);
      in_data  = 8'(idx + 1);
      #1;
      if (out_valid) begin
        check("bp_order", out_data, 4'(got + 1));
        got++;
      end
      if (in_valid && in_ready) idx++;
      tick();
    end
    in_valid = 1'b0;
    check("bp_received", got, 4);

    // Saturating counter: 260 overflowing words at full rate.
    cnt_clr = 1'b1;
    tick();
    cnt_clr  = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'h40;
    sat_en   = 1'b1;
    for (int c = 0; c < 260; c++) tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    check("cnt_saturated", ovf_count, 8'd255);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    check("clr_word_valid", out_valid, 1'b1);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    check("clr_wins", ovf_count, 8'd0);

    // Mid-stream reset with two words buffered.
    send_one("pre_rst", 8'h40, 1'b1, 4'h7, 8'h07, 1'b1);
    check("pre_rst_cnt", ovf_count, 8'd1);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h11;
    tick();
    in_data = 8'h12;
    tick();
    check("buf_in_ready", in_ready, 1'b0);
    reset   = 1'b1;
    in_data = 8'h13;
    tick();
    reset    = 1'b0;
    in_valid = 1'b0;
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_cnt", ovf_count, 8'd0);
    check("mid_rst_in_ready", in_ready, 1'b1);
    tick();
    check("mid_rst_no_ghost", out_valid, 1'b0);
    send_one("post_rst", 8'h03, 1'b0, 4'h3, 8'h03, 1'b0);

    // Random valid/ready traffic against the reference model.
    sent = 0;
    recv = 0;
    ovfs = 0;
    cyc  = 0;
    while ((sent < 1000 || q.size() != 0) && cyc < 20000) begin
      in_valid  = (sent < 1000) && ($urandom_range(0, 3) != 0);
      in_data   = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 255))
                                              : 8'($urandom_range(0, 15) - 8);
      sat_en    = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("rnd_unexpected_word", 1'b1, 1'b0);
        end else begin
          ent = q.pop_front();
          check("rnd_data", out_data, ent[4:1]);
          check("rnd_ovf", out_ovf, ent[0]);
          check("rnd_ext", out_ext, {{4{ent[4]}}, ent[4:1]});
          if (ent[0]) ovfs++;
          recv++;
        end
      end
      if (in_valid && in_ready) begin
        ref_narrow(in_data, sat_en, md, mo);
        q.push_back({7'(0), md, mo});
        sent++;
      end
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    check("rnd_budget", (cyc < 20000), 1'b1);
    check("rnd_recv", recv, 1000);
    check("rnd_cnt", ovf_count, (ovfs > 255) ? 255 : ovfs);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
